sd_sector_streamer: RTL and testbench

- Downstream consumer of sd_controller: reads a run of consecutive 512-byte sectors and buffers the bytes in an internal FIFO.
- Game logic (note/audio fetch) drains the FIFO at its own pace.
- Gates sd_controller read requests so a sector is only requested when the FIFO can absorb all 512 bytes, because sd_controller cannot be stalled mid-sector.

---
 rtl/sd_sector_streamer.sv | 133 +++++++++++++
 tb/tb_sd_sector_streamer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: reads a run of 512-byte SD sectors into a first-word-fall-through byte FIFO.
// Optional macro SD_STREAM_LOOP_EN: restart at START_SECTOR after NUM_SECTORS instead of finishing.
module sd_sector_streamer #(
  parameter int START_SECTOR = 0,
  parameter int NUM_SECTORS  = 16,
  parameter int FIFO_DEPTH   = 1024,
  parameter int ADDR_SHIFT   = 9
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        sd_rd,
  output logic [31:0]                 sd_address,
  input  logic                        sd_ready,
  input  logic                        sd_byte_available,
  input  logic [7:0]                  sd_dout,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  input  logic                        pop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 sector_count,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SD_STREAM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT_ROOM, ISSUE, STREAM, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic ba_q, rd_q, done_q, error_q;
  logic [31:0] idx_q;
  logic [15:0] count_q;
  logic [9:0] byte_cnt_q;
  logic [AW:0] level_q;
  logic [AW-1:0] wr_q, rd_ptr_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic kick, rise, room, full, take, push, popv, last;

  assign rise = sd_byte_available & ~ba_q;
  assign full = level_q == (AW+1)'(FIFO_DEPTH);
  assign room = level_q <= (AW+1)'(FIFO_DEPTH - 512);
  assign take = state_q == STREAM && rise && byte_cnt_q != 10'd512;
  assign push = take & ~full;
  assign popv = pop & (level_q != '0);
  assign last = count_q + 16'd1 == 16'(NUM_SECTORS);

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  // next state: a sector is only requested once the FIFO can take all of it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? WAIT_ROOM : state_q;
      WAIT_ROOM:  state_d = room && sd_ready ? ISSUE : WAIT_ROOM;
      ISSUE:      state_d = rd_q && !sd_ready ? STREAM : ISSUE;
      STREAM:     state_d = !sd_ready ? STREAM : byte_cnt_q == 10'd512 ? NEXT : DONE;
      NEXT:       state_d = error_q || (last && !LOOP) ? DONE : WAIT_ROOM;
      default:    state_d = IDLE;
    endcase
  end

  // state decode into run-level strobes
  always_comb begin
    busy = state_q inside {WAIT_ROOM, ISSUE, STREAM, NEXT};
    kick = start && (state_q == IDLE || state_q == DONE);
  end

  // run bookkeeping: read handshake, byte/sector counters, sticky status
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ba_q       <= 1'b0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      ba_q <= sd_byte_available;
      rd_q <= state_q == ISSUE && !(rd_q && !sd_ready);
      if (kick) begin
        idx_q   <= 32'(START_SECTOR);
        count_q <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if (state_q == ISSUE) byte_cnt_q <= '0;
      if (take) byte_cnt_q <= byte_cnt_q + 10'd1;
      if (state_q == STREAM && ((rise && (byte_cnt_q == 10'd512 || full)) || (sd_ready && byte_cnt_q != 10'd512)))
        error_q <= 1'b1;
      if (state_q == NEXT) begin
        idx_q   <= LOOP && last ? 32'(START_SECTOR) : idx_q + 32'd1;
        count_q <= LOOP && last ? '0 : count_q + 16'd1;
        done_q  <= !LOOP && last && !error_q;
      end
    end

  // FIFO pointers and occupancy; a new run empties it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q     <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (kick) begin
      wr_q     <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_q     <= wr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(popv);
      level_q  <= level_q + (AW+1)'(push) - (AW+1)'(popv);
    end

  // FIFO storage
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= sd_dout;

  assign sd_rd        = rd_q;
  assign sd_address   = idx_q << ADDR_SHIFT;
  assign data_valid   = level_q != '0;
  assign data_out     = data_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_level   = level_q;
  assign sector_count = count_q;
  assign done         = done_q;
  assign error        = error_q;
endmodule

// File: tb/tb_sd_sector_streamer.sv
// tb_sd_sector_streamer: directed tests with a byte-queue FIFO model checked every cycle
module tb_sd_sector_streamer;
`ifdef SD_STREAM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, start_a, start_b, pop, sd_ready, sd_ba, sel;
  logic [7:0] sd_dout;
  logic rd_a, dv_a, busy_a, done_a, err_a, rd_b, dv_b, busy_b, done_b, err_b;
  logic [31:0] addr_a, addr_b;
  logic [7:0] dout_a, dout_b;
  logic [10:0] lvl_a, lvl_b;
  logic [15:0] sc_a, sc_b;

  sd_sector_streamer #(.START_SECTOR(0), .NUM_SECTORS(2), .FIFO_DEPTH(1024), .ADDR_SHIFT(9)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .start(start_a), .sd_rd(rd_a), .sd_address(addr_a),
    .sd_ready(sd_ready), .sd_byte_available(sd_ba), .sd_dout(sd_dout), .data_out(dout_a),
    .data_valid(dv_a), .pop(pop), .fifo_level(lvl_a), .sector_count(sc_a), .busy(busy_a),
    .done(done_a), .error(err_a));

  sd_sector_streamer #(.START_SECTOR(5), .NUM_SECTORS(3), .FIFO_DEPTH(1024), .ADDR_SHIFT(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .start(start_b), .sd_rd(rd_b), .sd_address(addr_b),
    .sd_ready(sd_ready), .sd_byte_available(sd_ba), .sd_dout(sd_dout), .data_out(dout_b),
    .data_valid(dv_b), .pop(pop), .fifo_level(lvl_b), .sector_count(sc_b), .busy(busy_b),
    .done(done_b), .error(err_b));

  wire        rd_s    = sel ? rd_b : rd_a;
  wire [31:0] addr_s  = sel ? addr_b : addr_a;
  wire [7:0]  dout_s  = sel ? dout_b : dout_a;
  wire        dv_s    = sel ? dv_b : dv_a;
  wire [10:0] lvl_s   = sel ? lvl_b : lvl_a;
  wire        rst_s   = sel ? rst_b_n : rst_a_n;
  wire        start_s = sel ? start_b : start_a;

  int checks = 0, failures = 0, n_pop = 0, n0;
  bit mon = 1'b0;
  logic ba_prev = 1'b0;
  logic [7:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // FIFO model: every byte the SD side offers is queued, pops take from the front
  always @(negedge clk) begin
    if (!rst_s) q.delete();
    else if (mon) begin
      chk("fifo_level", 32'(lvl_s), q.size());
      chk("data_valid", 32'(dv_s), 32'(q.size() != 0));
      if (q.size() != 0) chk("data_out", 32'(dout_s), 32'(q[0]));
      if (start_s) q.delete();
      else begin
        if (pop && q.size() != 0) begin
          void'(q.pop_front());
          n_pop++;
        end
        if (sd_ba && !ba_prev) q.push_back(sd_dout);
      end
    end
    ba_prev = sd_ba;
  end

  // SD controller model: answer one read request with n bytes valued index mod 256
  task automatic serve(input logic [31:0] exp_addr, input int n, input int hi, input bit fin);
    int t = 0;
    while (rd_s !== 1'b1 && t < 3000) begin
      cyc(1);
      t++;
    end
    if (rd_s !== 1'b1) begin
      chk("rd_timeout", 32'(rd_s), 1);
      return;
    end
    chk("sd_address", addr_s, exp_addr);
    sd_ready = 1'b0;
    cyc(3);
    chk("rd_released", 32'(rd_s), 0);
    for (int i = 0; i < n; i++) begin
      sd_dout = 8'(i);
      sd_ba = 1'b1;
      cyc(hi);
      sd_ba = 1'b0;
      cyc(2);
    end
    if (fin) begin
      sd_ready = 1'b1;
      cyc(2);
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    cyc(1);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    cyc(1);
    start_b = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit rd_seen;
    rst_a_n = 0; rst_b_n = 0; start_a = 0; start_b = 0; pop = 0;
    sd_ready = 1; sd_ba = 0; sd_dout = 0; sel = 0;
    cyc(3);
    chk("reset_a_ctrl", {rd_a, dv_a, busy_a, done_a, err_a}, 0);
    chk("reset_a_addr", addr_a, 0);
    chk("reset_a_data", {dout_a, lvl_a, sc_a}, 0);
    chk("reset_b", {rd_b, dv_b, busy_b, done_b, err_b, lvl_b, sc_b}, 0);
    rst_a_n = 1; rst_b_n = 1; mon = 1;
    cyc(2);
    // two-sector run, drained as it arrives
    pop = 1; n0 = n_pop;
    pulse_a();
    chk("t1_busy", 32'(busy_a), 1);
    serve(32'h0, 512, 1, 1);
    serve(32'h200, 512, 1, 1);
    cyc(6);
    chk("t1_pops", n_pop - n0, 1024);
    chk("t1_done", 32'(done_a), 32'(!LOOP));
    chk("t1_err", 32'(err_a), 0);
    chk("t1_count", 32'(sc_a), LOOP ? 0 : 2);
    chk("t1_busy_end", 32'(busy_a), 32'(LOOP));
`ifdef SD_STREAM_LOOP_EN
    serve(32'h0, 512, 1, 1);
    chk("loop_done", 32'(done_a), 0);
    rst_a_n = 0; cyc(1); rst_a_n = 1; cyc(1);
`endif
    // short sector
    pop = 0;
    pulse_a();
    serve(32'h0, 300, 1, 1);
    cyc(3);
    chk("short_err", 32'(err_a), 1);
    chk("short_done", 32'(done_a), 0);
    chk("short_busy", 32'(busy_a), 0);
    chk("short_level", 32'(lvl_a), 300);
    // stretched byte_available
    pop = 1; n0 = n_pop;
    pulse_a();
    chk("restart_err_clr", 32'(err_a), 0);
    serve(32'h0, 512, 3, 1);
    serve(32'h200, 512, 3, 1);
    cyc(6);
    chk("stretch_pops", n_pop - n0, 1024);
    chk("stretch_err", 32'(err_a), 0);
    chk("stretch_done", 32'(done_a), 32'(!LOOP));
`ifdef SD_STREAM_LOOP_EN
    rst_a_n = 0; cyc(1); rst_a_n = 1;
`endif
    cyc(4);
    // back-pressure on the second instance
    sel = 1; pop = 0;
    cyc(2);
    pulse_b();
    serve(32'd5, 512, 1, 1);
    serve(32'd6, 512, 1, 1);
    rd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_b) rd_seen = 1;
      cyc(1);
    end
    chk("bp_no_rd", 32'(rd_seen), 0);
    chk("bp_level_full", 32'(lvl_b), 1024);
    chk("bp_busy", 32'(busy_b), 1);
    pop = 1;
    cyc(512);
    pop = 0;
    serve(32'd7, 512, 1, 1);
    cyc(4);
    chk("bp_level_final", 32'(lvl_b), 1024);
    chk("bp_count", 32'(sc_b), LOOP ? 0 : 3);
    chk("bp_done", 32'(done_b), 32'(!LOOP));
    // asynchronous reset in the middle of a sector
    rst_b_n = 0; cyc(1); rst_b_n = 1; cyc(1);
    pulse_b();
    serve(32'd5, 100, 1, 0);
    cyc(2);
    rst_b_n = 0;
    #1;
    chk("arst_rd", 32'(rd_b), 0);
    chk("arst_level", 32'(lvl_b), 0);
    chk("arst_busy", 32'(busy_b), 0);
    sd_ready = 1; sd_ba = 0;
    cyc(2);
    rst_b_n = 1;
    cyc(1);
    pulse_b();
    serve(32'd5, 512, 1, 1);
    cyc(4);
    chk("arst_count", 32'(sc_b), 1);
    chk("arst_level_after", 32'(lvl_b), 512);
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
